fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Owns the architectural PC register of the RV32I core and sequences instruction fetch against instruction memory.
- One outstanding request at a time over a req/ready/rvalid handshake.
- Presents the fetched word to decode with a valid/ack handshake.
- Generates pc_stall for the PC controller and applies redirects (jump, branch, trap), discarding stale in-flight responses.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on instr when no valid instruction is held (addi x0,x0,0)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
next_pc  input  32  next PC from PC controller (target on redirect, pc+4 otherwise)
redirect  input  1  jump | branch_taken | trapped; next_pc is the redirect target this cycle
write_done  input  1  data-memory write complete; 0 blocks sequential PC advance
pipe_stall  input  1  downstream hazard stall; 1 blocks sequential PC advance
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (= pc)
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid (exactly one per accepted request)
imem_rdata  input  32  instruction word
pc  output  32  current PC
instr  output  32  fetched instruction to decode
instr_valid  output  1  instr holds a valid word for pc
instr_ack  input  1  decode consumes instr this cycle
pc_stall  output  1  1 = PC not updated this cycle (fed to PC controller)

Behaviour:
- Reset (async, reset_n=0): pc=RESET_VECTOR, state=BOOT, imem_req=0, instr_valid=0, instr=NOP_INSTR, pc_stall=1. Reset mid-transaction abandons it; a late rvalid after reset is ignored while in BOOT.
- States: BOOT, REQ, WAIT, HOLD, DROP. State and outputs are registered; pc_stall and imem_addr are combinational from state, pc and inputs.
- BOOT: one cycle, then REQ. redirect is ignored in BOOT.
- REQ: imem_req=1, imem_addr=pc.
  - imem_ready=1 -> WAIT.
  - redirect=1 with imem_ready=0: pc<=next_pc, stay in REQ. The address may change only in this case; memory must not latch an unaccepted address.
  - redirect=1 with imem_ready=1 (same cycle): pc<=next_pc, -> DROP, because the old fetch is in flight.
- WAIT: imem_req=0.
  - imem_rvalid=1 and redirect=0: instr<=imem_rdata, instr_valid<=1, -> HOLD.
  - redirect=1: pc<=next_pc. If imem_rvalid=1 in the same cycle, discard the data and go to REQ; otherwise go to DROP.
- DROP: imem_req=0, instr_valid=0.
  - imem_rvalid=1: discard the data, -> REQ.
  - redirect=1: pc<=next_pc, stay in DROP. If rvalid arrives in the same cycle, go to REQ.
- HOLD: instr_valid=1.
  - redirect=1: pc<=next_pc, instr_valid<=0, instr<=NOP_INSTR, -> REQ. Redirect wins over ack.
  - Otherwise, advance when instr_ack && write_done && !pipe_stall: pc<=next_pc, instr_valid<=0, -> REQ.
  - ack with write_done=0 or pipe_stall=1: hold everything, including instr and pc.
- pc_stall = ~pc_update. pc_update=1 exactly in the cycles where pc is loaded above. pc never changes when pc_stall=1.
- Redirect is honoured regardless of write_done/pipe_stall. The upstream trap/branch logic owns ordering against pending writes.
- Latency: zero-wait memory (ready=1, rvalid the cycle after acceptance) yields a REQ->WAIT->HOLD sequence. With immediate ack, one instruction retires per 3 cycles.
- No arithmetic in this block; pc+4 wrap (32'hFFFF_FFFC -> 0) comes from next_pc unchanged.
- Misaligned next_pc is loaded as-is. Alignment traps are the trap unit's job.

Test Plan:
- Reset release, memory ready=1, rvalid 1 cycle later, rdata=32'h00500093, ack held 1 -> pc=0, BOOT then REQ at cycle 1, instr_valid at cycle 3 with instr=32'h00500093, pc advances to 4 with pc_stall=0 for exactly that cycle.
- In HOLD, ack=1, write_done=0 for 4 cycles then 1 -> pc stays 0 and pc_stall=1 for those 4 cycles; pc=4 the cycle write_done rises. Repeat with pipe_stall=1 and expect the same result.
- In WAIT, redirect=1 with next_pc=32'h10; rvalid arrives 2 cycles later with 32'hDEADBEEF -> enters DROP, instr_valid stays 0, the word is discarded, next imem_addr=32'h10.
- In HOLD, redirect=1 and instr_ack=1 together with next_pc=32'h30 -> pc=32'h30, instr_valid=0, instr=NOP, next request to 32'h30.
- imem_ready held 0 for 3 cycles, redirect to 32'h20 in the 2nd cycle -> imem_addr 0,0 then 32'h20, accepted at 32'h20, no DROP entered.
- Assert reset_n=0 mid-WAIT, release, then inject a stray rvalid in BOOT -> pc=RESET_VECTOR, instr_valid=0, stray data ignored, normal fetch from RESET_VECTOR.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC and sequences single-outstanding instruction fetch,
// handing fetched words to decode and squashing in-flight responses on redirect.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic        write_done,
    input  logic        pipe_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic        pc_stall
);

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        pc_update;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        pc_update = 1'b0;
        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                pc_update = redirect;
                // A redirect on the accept cycle leaves a stale fetch in flight.
                if (imem_ready) state_d = redirect ? DROP : WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    pc_update = 1'b1;
                    state_d   = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Redirect takes priority over ack and ignores write/hazard stalls.
                if (redirect || (instr_ack && write_done && !pipe_stall)) begin
                    pc_update = 1'b1;
                    valid_d   = 1'b0;
                    instr_d   = NOP_INSTR;
                    state_d   = REQ;
                end
            end
            DROP: begin
                pc_update = redirect;
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = BOOT;
        endcase
        pc_d = pc_update ? next_pc : pc_q;
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc_stall    = ~pc_update;

endmodule
